// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: walks every input vector through a combinational FUT and checks it against a golden table.
// Optional feature: define TT_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module tt_sweep_ctrl #(
    parameter int                  N_IN        = 3,
    parameter logic [2**N_IN-1:0]  EXPECTED    = 8'hE8,
    parameter int                  HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [N_IN-1:0] LAST_VEC  = '1;
    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);
    localparam logic [3:0]      HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0]      CNT_ONE   = 4'd1;

    state_t            r_state;
    logic [N_IN-1:0]   r_vec;
    logic [3:0]        r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN:0]     r_err;
    logic [N_IN-1:0]   r_failIdx;

    logic              w_mismatch;
    logic              w_errSat;
    logic              w_endSweep;

    assign w_mismatch = (dut_out != EXPECTED[r_vec]);
    assign w_errSat   = &r_err;

    // The sweep ends on the terminal vector, or on the first mismatch when early stop is built in.
`ifdef TT_STOP_ON_ERR_EN
    assign w_endSweep = w_mismatch || (r_vec == LAST_VEC);
`else
    assign w_endSweep = (r_vec == LAST_VEC);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_vec     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
            r_failIdx <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= APPLY;
                        r_vec     <= '0;
                        r_cnt     <= '0;
                        r_err     <= '0;
                        r_failIdx <= '0;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                APPLY: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                SAMPLE: begin
                    // fail_idx latches only while no error has been counted yet
                    if (w_mismatch) begin
                        if (!w_errSat) begin
                            r_err <= r_err + ERR_ONE;
                        end
                        if (r_err == '0) begin
                            r_failIdx <= r_vec;
                        end
                    end
                    if (w_endSweep) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_vec   <= r_vec + VEC_ONE;
                        r_cnt   <= '0;
                        r_state <= APPLY;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == '0);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dut_in    = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_idx  = r_failIdx;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: table-driven and randomized checks of tt_sweep_ctrl driving a truth-table FUT.
// Expectations adapt when TT_STOP_ON_ERR_EN is defined.
module tb_tt_sweep_ctrl;

    localparam int          HOLD   = 1;
    localparam logic [7:0]  GOLDEN = 8'hE8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] dutIn;
    logic       dutOut;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] errCount;
    logic [2:0] failIdx;
    logic [7:0] futTable;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [7:0] tbl;
        int         expErr;
        int         expIdx;
        int         startAgainAt;
        string      name;
    } vector_t;

    vector_t vectors[9];

    tt_sweep_ctrl #(
        .N_IN        (3),
        .EXPECTED    (GOLDEN),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dut_in    (dutIn),
        .dut_out   (dutOut),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (errCount),
        .fail_idx  (failIdx)
    );

    always #5 clk = ~clk;

    // The FUT is an arbitrary truth table indexed by the applied vector.
    assign dutOut = futTable[dutIn];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Counts mismatching vectors and finds the lowest one from the rules alone.
    function automatic void refModel(input logic [7:0] tbl, output int errs, output int first);
        logic [7:0] gold;
        gold  = GOLDEN;
        errs  = 0;
        first = -1;
        for (int v = 0; v < 8; v++) begin
            if (tbl[v] != gold[v]) begin
                errs++;
                if (first < 0) first = v;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] tbl, input int expErrIn, input int expIdx,
                                 input int startAgainAt, input string name);
        int   expErr;
        int   lastVec;
        int   doneExp;
        int   expDutIn;
        logic expPass;
        expErr  = expErrIn;
        expPass = (expErrIn == 0);
        lastVec = 7;
`ifdef TT_STOP_ON_ERR_EN
        if (expErr > 0) begin
            expErr  = 1;
            lastVec = expIdx;
        end
`endif
        doneExp  = 1 + (lastVec + 1) * (HOLD + 1);
        futTable = tbl;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= doneExp + 3; n++) begin
            if (n > 0) begin
                @(negedge clk);
                start = (n == startAgainAt);
            end
            expDutIn = n / (HOLD + 1);
            if (expDutIn > lastVec) expDutIn = lastVec;
            checkOutput({name, " done"}, done, (n == doneExp));
            checkOutput({name, " busy"}, busy, (n < doneExp - 1));
            checkOutput({name, " dut_in"}, dutIn, expDutIn);
            if (n == doneExp) begin
                checkOutput({name, " err_count"}, errCount, expErr);
                checkOutput({name, " fail_idx"}, failIdx, expIdx);
                checkOutput({name, " pass"}, pass, expPass);
            end else if (n > doneExp) begin
                checkOutput({name, " pass held"}, pass, expPass);
            end else begin
                checkOutput({name, " pass cleared"}, pass, 0);
            end
        end
        start = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " dut_in"}, dutIn, 0);
        checkOutput({name, " busy"}, busy, 0);
        checkOutput({name, " done"}, done, 0);
        checkOutput({name, " pass"}, pass, 0);
        checkOutput({name, " err_count"}, errCount, 0);
        checkOutput({name, " fail_idx"}, failIdx, 0);
    endtask

    initial begin
        int         errs;
        int         first;
        int         doneSeen;
        int         expErrMid;
        logic [7:0] rndTbl;

        vectors[0] = '{8'hE8, 0, 0, -1, "majority"};
        vectors[1] = '{8'h00, 4, 3, -1, "stuck0"};
        vectors[2] = '{8'h17, 8, 0, -1, "inverted"};
        vectors[3] = '{8'hFF, 4, 0, -1, "stuck1"};
        vectors[4] = '{8'hE9, 1, 0, -1, "flip0"};
        vectors[5] = '{8'hEC, 1, 2, -1, "flip2"};
        vectors[6] = '{8'h68, 1, 7, -1, "flip7"};
        vectors[7] = '{8'hE8, 0, 0, 4, "startBusy"};
        vectors[8] = '{8'hE8, 0, 0, 16, "startDone"};

        reset    = 1'b1;
        start    = 1'b0;
        futTable = GOLDEN;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].tbl, vectors[i].expErr, vectors[i].expIdx,
                          vectors[i].startAgainAt, vectors[i].name);
        end

        // Reset while idle with pass=1 and dut_in=7, start held alongside reset.
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("idleReset");
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("startWithReset busy", busy, 0);

        // Reset in the middle of a sweep, at vector 5.
`ifdef TT_STOP_ON_ERR_EN
        futTable  = GOLDEN;
        expErrMid = 0;
`else
        futTable  = 8'h00;
        expErrMid = 1;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midReset vec5", dutIn, 5);
        checkOutput("midReset errBefore", errCount, expErrMid);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkAllZero("midReset");
        doneSeen = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("midReset noDone", doneSeen, 0);
        checkOutput("midReset idle", busy, 0);

        for (int i = 0; i < 16; i++) begin
            rndTbl = 8'($urandom);
            refModel(rndTbl, errs, first);
            applyStimulus(rndTbl, errs, (first < 0) ? 0 : first, -1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
